sdram_rw_arbiter: RTL and testbench

SDRAM_RW_ARBITER -- requirements
Module: sdram_rw_arbiter

---
 rtl/sdram_rw_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sdram_rw_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_arbiter.sv
// Shares one SDRAM command port between camera write bursts and VGA read
// bursts, keeping a per-frame word offset for each side of the frame buffer.
module sdram_rw_arbiter #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned RD_LOW_MARK = 128
) (
  input  logic        clk,
  input  logic        rst_133,
  input  logic        sdram_init_done,
  input  logic [1:0]  cam_bank,
  input  logic [1:0]  vga_bank,
  input  logic        cam_frame_start,
  input  logic        vga_frame_start,
  input  logic [10:0] wr_fifo_level,
  input  logic [10:0] rd_fifo_level,
  input  logic        cmd_ready,
  input  logic        burst_done,
  output logic        cmd_valid,
  output logic        cmd_wr,
  output logic [21:0] cmd_addr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4
  } state_t;

  localparam logic [19:0] FRAME_PTR = 20'(FRAME_WORDS);
  localparam logic [20:0] BURST_INC = 21'(BURST_LEN);
  localparam logic [11:0] LOW_MARK  = 12'(RD_LOW_MARK);
  localparam logic [11:0] BURST_LVL = 12'(BURST_LEN);
  localparam logic [11:0] DEPTH_LVL = 12'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [21:0] cmd_addr_q, cmd_addr_d;
  logic        busy_q, busy_d;
  logic [19:0] wr_ptr_q, wr_ptr_d;
  logic [19:0] rd_ptr_q, rd_ptr_d;
  logic        cam_pend_q, cam_pend_d;
  logic        vga_pend_q, vga_pend_d;

  logic [19:0] wr_ptr_eff;
  logic [19:0] rd_ptr_eff;
  logic        cam_restart;
  logic        vga_restart;
  logic        rd_urgent;
  logic        wr_ok;
  logic        rd_ok;
  logic        issue_rd;
  logic        issue_wr;

  // Advance by one burst, clamped so a pointer never passes the frame end.
  function automatic logic [19:0] ptr_advance(input logic [19:0] ptr);
    logic [20:0] sum;
    sum = {1'b0, ptr} + BURST_INC;
    if (sum > {1'b0, FRAME_PTR}) begin
      return FRAME_PTR;
    end else begin
      return sum[19:0];
    end
  endfunction

  // A frame start seen in IDLE already counts for this cycle's arbitration.
  assign wr_ptr_eff  = ((state_q == IDLE) && cam_frame_start) ? 20'd0 : wr_ptr_q;
  assign rd_ptr_eff  = ((state_q == IDLE) && vga_frame_start) ? 20'd0 : rd_ptr_q;
  assign cam_restart = cam_pend_q | cam_frame_start;
  assign vga_restart = vga_pend_q | vga_frame_start;

  assign rd_urgent = ({1'b0, rd_fifo_level} < LOW_MARK) && (rd_ptr_eff < FRAME_PTR);
  assign wr_ok     = ({1'b0, wr_fifo_level} >= BURST_LVL) && (wr_ptr_eff < FRAME_PTR);
  assign rd_ok     = (({1'b0, rd_fifo_level} + BURST_LVL) <= DEPTH_LVL) && (rd_ptr_eff < FRAME_PTR);
  assign issue_rd  = sdram_init_done && (rd_urgent || (!wr_ok && rd_ok));
  assign issue_wr  = sdram_init_done && !rd_urgent && wr_ok;

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign busy      = busy_q;

  // Next-state, command and pointer logic.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    busy_d      = busy_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cam_pend_d  = cam_restart;
    vga_pend_d  = vga_restart;
    case (state_q)
      IDLE: begin
        wr_ptr_d   = wr_ptr_eff;
        rd_ptr_d   = rd_ptr_eff;
        cam_pend_d = 1'b0;
        vga_pend_d = 1'b0;
        if (issue_rd) begin
          state_d     = RD_REQ;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = 1'b0;
          cmd_addr_d  = {vga_bank, rd_ptr_eff};
          busy_d      = 1'b1;
        end else if (issue_wr) begin
          state_d     = WR_REQ;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = 1'b1;
          cmd_addr_d  = {cam_bank, wr_ptr_eff};
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ, RD_REQ: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (burst_done) begin
          busy_d     = 1'b0;
          state_d    = IDLE;
          cam_pend_d = 1'b0;
          vga_pend_d = 1'b0;
          // A restart requested during the burst wins over that burst's advance.
          if (cam_restart) begin
            wr_ptr_d = 20'd0;
          end else if (state_q == WR_WAIT) begin
            wr_ptr_d = ptr_advance(wr_ptr_q);
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
          if (vga_restart) begin
            rd_ptr_d = 20'd0;
          end else if (state_q == RD_WAIT) begin
            rd_ptr_d = ptr_advance(rd_ptr_q);
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
        cam_pend_d  = 1'b0;
        vga_pend_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= 22'd0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= 20'd0;
      rd_ptr_q    <= 20'd0;
      cam_pend_q  <= 1'b0;
      vga_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cam_pend_q  <= cam_pend_d;
      vga_pend_q  <= vga_pend_d;
    end
  end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Scoreboard bench for sdram_rw_arbiter: a transaction-level model predicts
// each SDRAM command; a monitor pops and compares whenever one appears.
module tb_sdram_rw_arbiter;

  localparam int BURST_LEN   = 256;
  localparam int FRAME_WORDS = 307200;
  localparam int FIFO_DEPTH  = 1024;
  localparam int RD_LOW_MARK = 128;

  logic        clk = 1'b0;
  logic        rst_133 = 1'b0;
  logic        sdram_init_done = 1'b0;
  logic [1:0]  cam_bank = 2'd0;
  logic [1:0]  vga_bank = 2'd0;
  logic        cam_frame_start = 1'b0;
  logic        vga_frame_start = 1'b0;
  logic [10:0] wr_fifo_level = 11'd0;
  logic [10:0] rd_fifo_level = 11'd0;
  logic        cmd_ready = 1'b0;
  logic        burst_done = 1'b0;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [21:0] cmd_addr;
  logic        busy;

  sdram_rw_arbiter dut (
    .clk(clk), .rst_133(rst_133), .sdram_init_done(sdram_init_done),
    .cam_bank(cam_bank), .vga_bank(vga_bank),
    .cam_frame_start(cam_frame_start), .vga_frame_start(vga_frame_start),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
    .cmd_ready(cmd_ready), .burst_done(burst_done),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: 0 = free, 1 = command offered, 2 = burst in flight
  int  m_state = 0, m_wr = 0, m_rd = 0, m_cmd_off = 0;
  bit  m_cam_p = 0, m_vga_p = 0, m_valid = 0, m_busy = 0, m_cmd_wr = 0;
  logic [22:0] exp_q[$];

  bit       g_init = 0, g_spur = 0;
  int       g_wrl = 0, g_rdl = 1024, g_rdy_mode = 0, g_bd_mode = 1;
  logic [1:0] g_cb = 2'd0, g_vb = 2'd0;

  int cmds_seen = 0, wr_seen = 0;
  bit last_wr = 0;
  int last_off = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_issue(input bit w);
    m_state   = 1;
    m_valid   = 1;
    m_busy    = 1;
    m_cmd_wr  = w;
    m_cmd_off = w ? m_wr : m_rd;
    exp_q.push_back({w, (w ? g_cb : g_vb), 20'(m_cmd_off)});
  endtask

  // Drive one cycle of inputs and advance the reference model across that edge.
  task automatic step(input bit rdy, input bit bd, input bit cfs, input bit vfs);
    bit urgent, wok, rok;
    @(negedge clk);
    sdram_init_done = g_init;
    cmd_ready       = rdy;
    burst_done      = bd;
    cam_frame_start = cfs;
    vga_frame_start = vfs;
    wr_fifo_level   = 11'(g_wrl);
    rd_fifo_level   = 11'(g_rdl);
    cam_bank        = g_cb;
    vga_bank        = g_vb;
    if (rst_133 !== 1'b1) return;
    if (m_state == 0) begin
      if (cfs) m_wr = 0;
      if (vfs) m_rd = 0;
      m_cam_p = 0;
      m_vga_p = 0;
      if (g_init) begin
        urgent = (g_rdl < RD_LOW_MARK) && (m_rd < FRAME_WORDS);
        wok    = (g_wrl >= BURST_LEN) && (m_wr < FRAME_WORDS);
        rok    = (FIFO_DEPTH - g_rdl >= BURST_LEN) && (m_rd < FRAME_WORDS);
        if (urgent) model_issue(1'b0);
        else if (wok) model_issue(1'b1);
        else if (rok) model_issue(1'b0);
      end
    end else begin
      m_cam_p = m_cam_p | cfs;
      m_vga_p = m_vga_p | vfs;
      if (m_state == 1 && rdy) begin
        m_valid = 0;
        m_state = 2;
      end else if (m_state == 2 && bd) begin
        m_busy  = 0;
        m_state = 0;
        if (m_cam_p) m_wr = 0;
        else if (m_cmd_wr) m_wr = (m_wr + BURST_LEN > FRAME_WORDS) ? FRAME_WORDS : m_wr + BURST_LEN;
        if (m_vga_p) m_rd = 0;
        else if (!m_cmd_wr) m_rd = (m_rd + BURST_LEN > FRAME_WORDS) ? FRAME_WORDS : m_rd + BURST_LEN;
        m_cam_p = 0;
        m_vga_p = 0;
      end
    end
  endtask

  task automatic tick(input bit cfs, input bit vfs);
    bit rdy, bd;
    case (g_rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
    if (m_state == 2) bd = (g_bd_mode == 1) || (g_bd_mode == 2 && $urandom_range(0, 2) == 0);
    else bd = g_spur && ($urandom_range(0, 19) == 0);
    step(rdy, bd, cfs, vfs);
  endtask

  task automatic reset_now();
    rst_133 = 1'b0;
    m_state = 0; m_wr = 0; m_rd = 0; m_cmd_off = 0;
    m_cam_p = 0; m_vga_p = 0; m_valid = 0; m_busy = 0; m_cmd_wr = 0;
    exp_q.delete();
  endtask

  task automatic wait_cmd(input string name, input int maxc);
    int start;
    int n;
    start = cmds_seen;
    n = 0;
    while (cmds_seen == start && n < maxc) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk(name, 32'(cmds_seen != start), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    g_wrl = 0;
    g_rdl = 1024;
    while (m_state != 0 && n < 50) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(m_state), 32'd0);
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each new command.
  initial begin
    logic prev_v;
    logic [22:0] cur;
    prev_v = 1'b0;
    cur = 23'd0;
    forever begin
      @(posedge clk);
      #2;
      chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      if (cmd_valid === 1'b1 && !prev_v) begin
        chk("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else cur = {cmd_wr, cmd_addr};
        cmds_seen++;
        last_wr  = cmd_wr;
        last_off = int'(cmd_addr[19:0]);
        if (cmd_wr) wr_seen++;
      end
      if (cmd_valid === 1'b1) chk("cmd_word", 32'({cmd_wr, cmd_addr}), 32'(cur));
      prev_v = cmd_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset_now();
    #1;
    chk("reset_valid", 32'(cmd_valid), 32'd0);
    chk("reset_addr", 32'(cmd_addr), 32'd0);
    repeat (3) tick(1'b0, 1'b0);
    #2 rst_133 = 1'b1;

    // init gating, then the held-off handshake with a bank change mid-request
    g_wrl = 512; g_rdl = 1024; g_cb = 2'd2; g_rdy_mode = 2; g_bd_mode = 1;
    repeat (10) tick(1'b0, 1'b0);
    chk("gated_no_cmd", 32'(cmd_valid), 32'd0);
    g_init = 1;
    wait_cmd("init_issue_timeout", 5);
    chk("init_wr", 32'(last_wr), 32'd1);
    chk("init_addr", 32'(cmd_addr), 32'({2'd2, 20'd0}));
    g_cb = 2'd1;
    repeat (5) tick(1'b0, 1'b0);
    chk("held_valid", 32'(cmd_valid), 32'd1);
    chk("held_addr", 32'(cmd_addr), 32'({2'd2, 20'd0}));
    g_rdy_mode = 0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("accept_valid_low", 32'(cmd_valid), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    tick(1'b0, 1'b0);
    chk("done_busy_low", 32'(busy), 32'd0);
    wait_cmd("second_wr_timeout", 10);
    chk("second_wr_off", 32'(last_off), 32'd256);

    // urgent read beats an eligible write
    drain();
    g_rdl = 100; g_wrl = 300;
    wait_cmd("prio_rd_timeout", 10);
    chk("prio_first_is_read", 32'(last_wr), 32'd0);
    chk("prio_read_off", 32'(last_off), 32'd0);
    g_rdl = 1024;
    wait_cmd("prio_wr_timeout", 10);
    chk("prio_then_write", 32'(last_wr), 32'd1);

    // full frame of writes, then stop until a new frame starts
    drain();
    g_wrl = 512;
    wr_seen = 0;
    tick(1'b1, 1'b0);
    n = 0;
    while (!(m_wr == FRAME_WORDS && m_state == 0) && n < 8000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    repeat (20) tick(1'b0, 1'b0);
    chk("frame_writes", 32'(wr_seen), 32'd1200);
    chk("frame_end_idle", 32'(cmd_valid), 32'd0);
    tick(1'b1, 1'b0);
    wait_cmd("restart_timeout", 10);
    chk("restart_wr", 32'(last_wr), 32'd1);
    chk("restart_off", 32'(last_off), 32'd0);

    // frame start during a burst at offset 1024
    n = 0;
    while (!(m_state == 2 && m_cmd_wr && m_cmd_off == 1024) && n < 100) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("reach_1024_timeout", 32'(m_cmd_off), 32'd1024);
    g_bd_mode = 0;
    tick(1'b1, 1'b0);
    g_bd_mode = 1;
    wait_cmd("midburst_timeout", 10);
    chk("midburst_restart_off", 32'(last_off), 32'd0);

    // randomized traffic
    g_rdy_mode = 1; g_bd_mode = 2; g_spur = 1;
    for (int i = 0; i < 3000; i++) begin
      g_init = ($urandom_range(0, 15) != 0);
      g_wrl  = $urandom_range(0, 1024);
      g_rdl  = $urandom_range(0, 1024);
      g_cb   = 2'($urandom_range(0, 3));
      g_vb   = 2'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 149) == 0));
    end

    // reset while a read burst is in flight
    g_init = 1; g_rdy_mode = 0; g_bd_mode = 1; g_spur = 0;
    drain();
    g_rdl = 100; g_wrl = 0; g_bd_mode = 0;
    n = 0;
    while (!(m_state == 2 && !m_cmd_wr) && n < 20) begin
      tick(1'($urandom_range(0, 0)), 1'b0);
      n++;
    end
    chk("reach_rd_wait_timeout", 32'(m_state), 32'd2);
    #1;
    reset_now();
    #1;
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_wr", 32'(cmd_wr), 32'd0);
    chk("rst_addr", 32'(cmd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    g_init = 0; g_wrl = 512; g_rdl = 1024; g_bd_mode = 1;
    repeat (3) tick(1'b0, 1'b0);
    #2 rst_133 = 1'b1;
    repeat (10) tick(1'b0, 1'b0);
    chk("post_rst_gated", 32'(cmd_valid), 32'd0);
    g_init = 1;
    wait_cmd("post_rst_timeout", 10);
    chk("post_rst_wr", 32'(last_wr), 32'd1);
    chk("post_rst_off", 32'(last_off), 32'd0);

    drain();
    repeat (5) tick(1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
